// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver: synchronizes rx, deserializes frames into a
// small FIFO and exposes data/status words for the IO page read mux.
module uart_rx_mmio #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DEPTH        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        rd_dat,
  input  logic        clr_err,
  output logic [31:0] dat_rdata,
  output logic [31:0] cntl_rdata
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [BW-1:0] HALF_LOAD = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] FULL_LOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HI
  } state_e;

  logic          rx_meta_q, rxs_q;
  state_e        state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    idx_q, idx_d;
  logic          push, frm_set;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovr_q, frm_q;
  logic          pop, push_ok, not_empty;

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // NOTE: clocked state uses non-blocking (<=) so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    push    = 1'b0;
    frm_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          cnt_d   = HALF_LOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rxs_q) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = FULL_LOAD;
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {rxs_q, shift_q[7:1]};
          cnt_d   = FULL_LOAD;
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rxs_q) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end else begin
          frm_set = 1'b1;
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pop is resolved before push, so a full FIFO being read still accepts a byte.
  assign not_empty = (count_q != '0);
  assign pop       = rd_dat & not_empty;
  assign push_ok   = push & ((count_q != FULL_CNT) | pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      frm_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_ok) - CW'(pop);
      ovr_q   <= (push & ~push_ok) | (ovr_q & ~clr_err);
      frm_q   <= frm_set | (frm_q & ~clr_err);
    end
  end

  // NOTE: storage is not reset; the count gates every read, so stale bytes are never visible.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  always_comb begin
    dat_rdata  = not_empty ? {24'b0, mem_q[rd_ptr_q]} : 32'b0;
    cntl_rdata = {20'b0, frm_q, ovr_q, 1'b0, not_empty, 8'(count_q)};
  end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Self-checking bench for uart_rx_mmio: directed scenarios plus random frames,
// compared against a frame-level queue model of the receiver.
module tb_uart_rx_mmio;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  localparam int LATENCY = 2 + CPB / 2 + 9 * CPB;

  logic        clk = 1'b0;
  logic        reset, rx, rd_dat, clr_err;
  logic [31:0] dat_rdata, cntl_rdata;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_q[$];
  logic       m_ovr, m_frm;

  uart_rx_mmio #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rd_dat     (rd_dat),
    .clr_err    (clr_err),
    .dat_rdata  (dat_rdata),
    .cntl_rdata (cntl_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- reference model: frame-level behaviour only ----
  function automatic void m_good_frame(input logic [7:0] b);
    if (m_q.size() < DEPTH) m_q.push_back(b);
    else m_ovr = 1'b1;
  endfunction

  function automatic void m_pop();
    if (m_q.size() > 0) void'(m_q.pop_front());
  endfunction

  function automatic void m_reset();
    m_q.delete();
    m_ovr = 1'b0;
    m_frm = 1'b0;
  endfunction

  function automatic logic [31:0] m_dat();
    return (m_q.size() > 0) ? {24'b0, m_q[0]} : 32'b0;
  endfunction

  function automatic logic [31:0] m_cntl();
    logic [7:0] n;
    n = 8'(m_q.size());
    return {20'b0, m_frm, m_ovr, 1'b0, (m_q.size() > 0), n};
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_dat"}, dat_rdata, m_dat());
    check({tag, "_cntl"}, cntl_rdata, m_cntl());
  endtask

  // ---- stimulus ----
  // stop_low = 0 sends a normal 1-period stop bit; otherwise the stop bit is
  // held low for that many periods, then the line idles high for 2 periods.
  task automatic send_frame(input logic [7:0] b, input int stop_low);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    if (stop_low == 0) begin
      rx = 1'b1;
      repeat (CPB) tick();
    end else begin
      rx = 1'b0;
      repeat (CPB * stop_low) tick();
      rx = 1'b1;
      repeat (2 * CPB) tick();
    end
  endtask

  task automatic pop_byte();
    rd_dat = 1'b1;
    tick();
    rd_dat = 1'b0;
    m_pop();
  endtask

  task automatic clear_err();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    m_ovr = 1'b0;
    m_frm = 1'b0;
  endtask

  initial begin
    int lat;
    bit seen;
    logic [7:0] b;
    bit bad;

    rx = 1'b1; rd_dat = 1'b0; clr_err = 1'b0; reset = 1'b1;
    m_reset();
    repeat (4) tick();
    check("reset_dat", dat_rdata, 32'h0);
    check("reset_cntl", cntl_rdata, 32'h0);
    reset = 1'b0;
    repeat (2) tick();

    // Single byte with latency measurement from the first edge sampling rx low.
    lat = -1;
    seen = 1'b0;
    fork
      send_frame(8'h55, 0);
      begin
        for (int n = 1; n <= 200 && !seen; n++) begin
          tick();
          if (cntl_rdata[8]) begin
            lat = n - 1;
            seen = 1'b1;
          end
        end
      end
    join
    check("latency", lat, LATENCY);
    m_good_frame(8'h55);
    check("single_dat", dat_rdata, 32'h0000_0055);
    check("single_count", {24'b0, cntl_rdata[7:0]}, 32'd1);
    pop_byte();
    check("single_pop_dat", dat_rdata, 32'h0);
    check("single_pop_count", {24'b0, cntl_rdata[7:0]}, 32'd0);
    tick();

    // Pop on an empty FIFO must change nothing.
    pop_byte();
    check_model("empty_pop");

    // Glitch shorter than half a bit period.
    rx = 1'b0;
    repeat (2) tick();
    rx = 1'b1;
    repeat (3 * CPB) tick();
    check("glitch_cntl", cntl_rdata, 32'h0);
    check("glitch_dat", dat_rdata, 32'h0);

    // Framing error on a long break, then a valid byte.
    send_frame(8'hA5, 3);
    m_frm = 1'b1;
    send_frame(8'h3C, 0);
    m_good_frame(8'h3C);
    check("frm_bit11", {31'b0, cntl_rdata[11]}, 32'd1);
    check_model("frm");
    clear_err();
    check_model("frm_clr");
    pop_byte();

    // clr_err coinciding with a new framing error leaves the bit set.
    fork
      send_frame(8'h99, 1);
      begin
        repeat (LATENCY) tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
      end
    join
    m_frm = 1'b1;
    check_model("clr_vs_set");
    clear_err();

    // Overrun: five bytes into a four-entry FIFO.
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i);
      send_frame(b, 0);
      m_good_frame(b);
    end
    check("ovr_count", {24'b0, cntl_rdata[7:0]}, 32'd4);
    check("ovr_bit10", {31'b0, cntl_rdata[10]}, 32'd1);
    check_model("ovr");
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovr_pop%0d", i), dat_rdata, 32'(i));
      pop_byte();
    end
    clear_err();
    check_model("ovr_drained");

    // Full FIFO plus rd_dat on the exact push cycle.
    for (int i = 0; i < 4; i++) begin
      b = 8'h10 + 8'(i);
      send_frame(b, 0);
      m_good_frame(b);
    end
    fork
      send_frame(8'h14, 0);
      begin
        repeat (LATENCY) tick();
        rd_dat = 1'b1;
        tick();
        rd_dat = 1'b0;
      end
    join
    m_pop();
    m_good_frame(8'h14);
    check("fullpop_ovr", {31'b0, cntl_rdata[10]}, 32'd0);
    check_model("fullpop");
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("fullpop_head%0d", i), dat_rdata, 32'h10 + 32'(i));
      pop_byte();
    end

    // Reset during data bit 4 of 0xFF, with a byte already queued.
    send_frame(8'h77, 0);
    m_good_frame(8'h77);
    fork
      send_frame(8'hFF, 0);
      begin
        repeat (2 + CPB / 2 + 4 * CPB + 2) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
      end
    join
    m_reset();
    check("rst_mid_dat", dat_rdata, 32'h0);
    check("rst_mid_cntl", cntl_rdata, 32'h0);
    send_frame(8'h42, 0);
    m_good_frame(8'h42);
    check("rst_after_dat", dat_rdata, 32'h0000_0042);
    check_model("rst_after");
    pop_byte();

    // Randomized frames, reads and error clears against the model.
    for (int it = 0; it < 30; it++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      if (bad) begin
        send_frame(b, int'($urandom_range(1, 2)));
        m_frm = 1'b1;
      end else begin
        send_frame(b, 0);
        m_good_frame(b);
      end
      check_model($sformatf("rnd%0d_rx", it));
      if ($urandom_range(0, 2) == 0) begin
        int k;
        k = int'($urandom_range(1, 3));
        for (int j = 0; j < k; j++) pop_byte();
        check_model($sformatf("rnd%0d_pop", it));
      end
      if ($urandom_range(0, 4) == 0) begin
        clear_err();
        check_model($sformatf("rnd%0d_clr", it));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
